pcie_irq_arb: RTL

PCIE_IRQ_ARB -- requirements
Module: pcie_irq_arb

---
 rtl/pcie_irq_arb.sv | 56 +++++
 1 files changed

// File: rtl/pcie_irq_arb.sv
// pcie_irq_arb: round-robin MSI arbiter for tx/rx interrupt pulses with post-grant holdoff
module pcie_irq_arb #(
  parameter logic [15:0] HOLDOFF = 16'd250,
  parameter logic [7:0]  TX_VEC  = 8'h01,
  parameter logic [7:0]  RX_VEC  = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_send_irq,
  input  logic        rx_send_irq,
  input  logic        cfg_interrupt_msienable,
  input  logic        cfg_interrupt_rdy_n,
  output logic        cfg_interrupt_n,
  output logic [7:0]  cfg_interrupt_di,
  output logic        cfg_interrupt_assert_n,
  output logic [31:0] irq_cnt
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  logic [1:0]  state;
  logic [15:0] cnt;
  logic        tx_pend, rx_pend, sel_rx, last_rx, hs;
  assign hs = (state == REQ) & ~cfg_interrupt_rdy_n;
  assign cfg_interrupt_n = state != REQ;
  assign cfg_interrupt_di = state == REQ ? (sel_rx ? RX_VEC : TX_VEC) : 8'h00;
  assign cfg_interrupt_assert_n = 1'b1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tx_pend <= 1'b0;
      rx_pend <= 1'b0;
      sel_rx  <= 1'b0;
      last_rx <= 1'b1;
      cnt     <= 16'd0;
      irq_cnt <= 32'd0;
    end else begin
      tx_pend <= tx_send_irq | (tx_pend & ~(hs & ~sel_rx));
      rx_pend <= rx_send_irq | (rx_pend & ~(hs & sel_rx));
      if (hs) begin
        irq_cnt <= irq_cnt + 32'd1;
        last_rx <= sel_rx;
        cnt     <= HOLDOFF;
      end
      case (state)
        IDLE: if ((tx_pend | rx_pend) & cfg_interrupt_msienable) begin
          state  <= REQ;
          sel_rx <= rx_pend & (~tx_pend | ~last_rx);
        end
        REQ: if (hs) state <= HOLD;
        HOLD: if (cnt == 16'd0) state <= IDLE; else cnt <= cnt - 16'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
